// File: rtl/rmux_pipe.sv
`default_nettype none
// ============================================================================
// Module   : rmux_pipe
// Purpose  : Data-phase-pipelined read-response multiplexer. Captures the
//            decoder's one-hot slave select when an address phase is
//            accepted and steers that slave's read data, ready and error
//            to the master during the following data phase. Non-one-hot
//            selects are answered by an internal default slave with a
//            two-cycle error. Slaves that stall too long are aborted with
//            the same two-cycle error plus a one-cycle TOUTEV pulse.
// Revision : 1.0 - initial release
// ============================================================================
module rmux_pipe #(
    parameter int NSLV = 16,   // number of slave ports (2..32)
    parameter int DW   = 39,   // read data width per slave
    parameter int TOUT = 255   // max wait cycles before abort, 0 = no abort
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [NSLV*DW-1:0]   SRDT,
    input  logic [NSLV-1:0]      SRDY,
    input  logic [NSLV-1:0]      SERR,
    input  logic [NSLV-1:0]      DmRMUX,
    input  logic                 MsREQ,
    output logic [DW-1:0]        MsRDT,
    output logic                 MsRDY,
    output logic                 MsERR,
    output logic                 TOUTEV
);

    // Wait counter is wide enough to hold TOUT; at least one bit so the
    // register exists even when the timeout is disabled.
    localparam int            CW      = (TOUT < 1) ? 1 : $clog2(TOUT + 1);
    localparam int            TLIM    = (TOUT < 1) ? 0 : TOUT - 1;
    localparam logic [CW-1:0] CNT_LIM = CW'(TLIM);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam bit            TOUT_EN = (TOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    state_t            state_q;
    logic [NSLV-1:0]   sel_q;
    logic [CW-1:0]     cnt_q;
    logic              toutev_q;

    logic [DW-1:0]     sel_rdt;
    logic              sel_rdy;
    logic              sel_err;
    logic              accept;
    logic              sel_onehot;

    // One-hot AND-OR mux of the captured slave; an empty select yields zeros.
    always_comb begin
        sel_rdt = '0;
        sel_rdy = 1'b0;
        sel_err = 1'b0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel_q[i]) begin
                sel_rdt = sel_rdt | SRDT[i*DW +: DW];
                sel_rdy = sel_rdy | SRDY[i];
                sel_err = sel_err | SERR[i];
            end
        end
    end

    // Master-side response decoded from the phase; DATA is a pure pass-through.
    always_comb begin
        MsRDT = '0;
        MsRDY = 1'b1;
        MsERR = 1'b0;
        case (state_q)
            ST_IDLE: begin
                MsRDT = '0;
                MsRDY = 1'b1;
                MsERR = 1'b0;
            end
            ST_DATA: begin
                MsRDT = sel_rdt;
                MsRDY = sel_rdy;
                MsERR = sel_err;
            end
            ST_ERR1: begin
                MsRDT = '0;
                MsRDY = 1'b0;
                MsERR = 1'b1;
            end
            ST_ERR2: begin
                MsRDT = '0;
                MsRDY = 1'b1;
                MsERR = 1'b1;
            end
            default: begin
                MsRDT = '0;
                MsRDY = 1'b1;
                MsERR = 1'b0;
            end
        endcase
    end

    assign TOUTEV     = toutev_q;
    assign accept     = MsREQ && MsRDY;
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign sel_onehot = (DmRMUX != '0) && ((DmRMUX & (DmRMUX - NSLV'(1))) == '0);

    // Phase sequencing: capture on accept, count stalls, abort on timeout.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            toutev_q <= 1'b0;
        end else begin
            toutev_q <= 1'b0;
            if (accept) begin
                // Any phase that shows MsRDY=1 can take the next address.
                sel_q   <= DmRMUX;
                cnt_q   <= '0;
                state_q <= sel_onehot ? ST_DATA : ST_ERR1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_IDLE;
                    end
                    ST_DATA: begin
                        if (sel_rdy) begin
                            state_q <= ST_IDLE;
                            sel_q   <= '0;
                        end else if (TOUT_EN && (cnt_q == CNT_LIM)) begin
                            // Drop the select so a late answer is masked.
                            state_q  <= ST_ERR1;
                            sel_q    <= '0;
                            toutev_q <= 1'b1;
                        end else if (TOUT_EN && (cnt_q != CNT_MAX)) begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    ST_ERR1: begin
                        state_q <= ST_ERR2;
                    end
                    ST_ERR2: begin
                        state_q <= ST_IDLE;
                        sel_q   <= '0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        sel_q   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rmux_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_rmux_pipe
// Purpose  : Self-checking bench for rmux_pipe (NSLV=16, DW=39, TOUT=4).
//            Directed scenarios plus randomized traffic, every cycle compared
//            against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rmux_pipe;

    localparam int NSLV = 16;
    localparam int DW   = 39;
    localparam int TOUT = 4;
    localparam logic [DW-1:0] RVAL = 39'h7F_1234_5678;

    logic                 CLK;
    logic                 nRST;
    logic [NSLV*DW-1:0]   SRDT;
    logic [NSLV-1:0]      SRDY;
    logic [NSLV-1:0]      SERR;
    logic [NSLV-1:0]      DmRMUX;
    logic                 MsREQ;
    logic [DW-1:0]        MsRDT;
    logic                 MsRDY;
    logic                 MsERR;
    logic                 TOUTEV;

    rmux_pipe #(.NSLV(NSLV), .DW(DW), .TOUT(TOUT)) dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .SRDT   (SRDT),
        .SRDY   (SRDY),
        .SERR   (SERR),
        .DmRMUX (DmRMUX),
        .MsREQ  (MsREQ),
        .MsRDT  (MsRDT),
        .MsRDY  (MsRDY),
        .MsERR  (MsERR),
        .TOUTEV (TOUTEV)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: what the master should be seeing, as a transfer view.
    // kind 0 = no transfer, 1 = talking to slave m_slave, 2 = error response
    int m_kind  = 0;
    int m_slave = 0;
    int m_waits = 0;
    int m_epos  = 0;
    bit m_tout  = 1'b0;

    task automatic model_expect(output logic [DW-1:0] rdt, output logic rdy,
                                output logic err, output logic tev);
        rdt = '0; rdy = 1'b1; err = 1'b0; tev = 1'b0;
        if (m_kind == 1) begin
            rdt = SRDT[m_slave*DW +: DW];
            rdy = SRDY[m_slave];
            err = SERR[m_slave];
        end else if (m_kind == 2) begin
            rdy = (m_epos == 1);
            err = 1'b1;
            tev = (m_epos == 0) && m_tout;
        end
    endtask

    task automatic model_advance();
        logic [DW-1:0] r;
        logic y, e, t;
        model_expect(r, y, e, t);
        if (MsREQ && y) begin
            if ($countones(DmRMUX) == 1) begin
                m_kind = 1;
                m_waits = 0;
                for (int i = 0; i < NSLV; i++) if (DmRMUX[i]) m_slave = i;
            end else begin
                m_kind = 2; m_epos = 0; m_tout = 1'b0;
            end
        end else if (m_kind == 1) begin
            if (SRDY[m_slave]) m_kind = 0;
            else begin
                m_waits++;
                if (TOUT != 0 && m_waits == TOUT) begin
                    m_kind = 2; m_epos = 0; m_tout = 1'b1;
                end
            end
        end else if (m_kind == 2) begin
            if (m_epos == 0) m_epos = 1;
            else m_kind = 0;
        end
    endtask

    task automatic to_neg();
        @(negedge CLK);
    endtask

    // Compare all outputs with the model, step the model, move past the edge.
    task automatic finish_cycle();
        logic [DW-1:0] er;
        logic ey, ee, et;
        model_expect(er, ey, ee, et);
        chk_val("m_rdt", MsRDT, er);
        chk_val("m_rdy", MsRDY, ey);
        chk_val("m_err", MsERR, ee);
        chk_val("m_tev", TOUTEV, et);
        model_advance();
        @(posedge CLK);
        #1;
    endtask

    task automatic cycle();
        to_neg();
        finish_cycle();
    endtask

    task automatic rand_data();
        for (int k = 0; k < NSLV; k++) SRDT[k*DW +: DW] = DW'({$urandom(), $urandom()});
    endtask

    logic [NSLV-1:0] pat;
    bit stall;

    initial begin
        nRST = 1'b0; MsREQ = 1'b0; DmRMUX = '0; SRDY = '0; SERR = '0; SRDT = '0;
        // Reset outputs before any clock edge
        #3;
        chk_val("rst_rdy", MsRDY, 1);
        chk_val("rst_err", MsERR, 0);
        chk_val("rst_rdt", MsRDT, 0);
        chk_val("rst_tev", TOUTEV, 0);
        #9 nRST = 1'b1;
        @(posedge CLK); #1;
        cycle();

        // Routing through every slave with two wait states
        for (int k = 0; k < NSLV; k++) begin
            rand_data();
            SRDY = '0; MsREQ = 1'b1; DmRMUX = NSLV'(1) << k;
            cycle();
            MsREQ = 1'b0; DmRMUX = NSLV'($urandom());
            SRDT[k*DW +: DW] = RVAL;
            for (int w = 0; w < 2; w++) begin
                to_neg();
                chk_val("route_wait", MsRDY, 0);
                finish_cycle();
            end
            SRDY = NSLV'(1) << k;
            to_neg();
            chk_val("route_rdy", MsRDY, 1);
            chk_val("route_rdt", MsRDT, RVAL);
            finish_cycle();
        end

        // Back-to-back: S3 zero wait, S12 accepted in the completing cycle
        rand_data();
        SRDY = '0; MsREQ = 1'b1; DmRMUX = 16'h0008;
        cycle();
        SRDY = 16'h0008; DmRMUX = 16'h1000;
        SRDT[3*DW +: DW] = 39'h12_3456_789A;
        to_neg();
        chk_val("bb_s3_rdy", MsRDY, 1);
        chk_val("bb_s3_rdt", MsRDT, 39'h12_3456_789A);
        finish_cycle();
        MsREQ = 1'b0; SRDY = 16'h1000;
        SRDT[12*DW +: DW] = 39'h45_6789_ABCD;
        to_neg();
        chk_val("bb_s12_rdt", MsRDT, 39'h45_6789_ABCD);
        chk_val("bb_s12_rdy", MsRDY, 1);
        finish_cycle();

        // Decode errors: empty and multi-bit selects
        for (int p = 0; p < 2; p++) begin
            pat = (p == 0) ? 16'h0000 : 16'h0011;
            rand_data();
            SRDY = '1; MsREQ = 1'b1; DmRMUX = pat;
            cycle();
            MsREQ = 1'b0;
            to_neg();
            chk_val("dec_e1_rdy", MsRDY, 0);
            chk_val("dec_e1_err", MsERR, 1);
            chk_val("dec_e1_tev", TOUTEV, 0);
            finish_cycle();
            to_neg();
            chk_val("dec_e2_rdy", MsRDY, 1);
            chk_val("dec_e2_err", MsERR, 1);
            chk_val("dec_e2_rdt", MsRDT, 0);
            finish_cycle();
        end

        // Timeout on S7, then a late ready that must be ignored
        rand_data();
        SRDY = '0; MsREQ = 1'b1; DmRMUX = 16'h0080;
        cycle();
        MsREQ = 1'b0;
        for (int c = 1; c <= TOUT; c++) begin
            to_neg();
            chk_val("to_wait", MsRDY, 0);
            chk_val("to_wait_tev", TOUTEV, 0);
            finish_cycle();
        end
        to_neg();
        chk_val("to_e1_tev", TOUTEV, 1);
        chk_val("to_e1_rdy", MsRDY, 0);
        chk_val("to_e1_err", MsERR, 1);
        finish_cycle();
        to_neg();
        chk_val("to_e2_rdy", MsRDY, 1);
        chk_val("to_e2_tev", TOUTEV, 0);
        finish_cycle();
        SRDY = '1; SERR = '1;
        to_neg();
        chk_val("late_rdt", MsRDT, 0);
        chk_val("late_err", MsERR, 0);
        finish_cycle();
        SERR = '0;

        // Slave S5 drives its own two-cycle error
        rand_data();
        SRDY = '0; MsREQ = 1'b1; DmRMUX = 16'h0020;
        cycle();
        MsREQ = 1'b0; SRDY = '0; SERR = 16'h0020;
        to_neg();
        chk_val("serr1_rdy", MsRDY, 0);
        chk_val("serr1_err", MsERR, 1);
        finish_cycle();
        SRDY = 16'h0020;
        to_neg();
        chk_val("serr2_rdy", MsRDY, 1);
        chk_val("serr2_err", MsERR, 1);
        chk_val("serr2_tev", TOUTEV, 0);
        finish_cycle();
        SERR = '0;

        // Asynchronous reset in the middle of a data phase
        rand_data();
        SRDY = '0; MsREQ = 1'b1; DmRMUX = 16'h0004;
        cycle();
        MsREQ = 1'b0;
        to_neg();
        chk_val("mid_rdy", MsRDY, 0);
        finish_cycle();
        #2 nRST = 1'b0;
        #1;
        chk_val("arst_rdy", MsRDY, 1);
        chk_val("arst_err", MsERR, 0);
        chk_val("arst_rdt", MsRDT, 0);
        m_kind = 0;
        #4 nRST = 1'b1;
        @(posedge CLK); #1;
        for (int c = 0; c < 3; c++) begin
            to_neg();
            chk_val("post_rst_rdy", MsRDY, 1);
            chk_val("post_rst_err", MsERR, 0);
            finish_cycle();
        end

        // Randomized traffic
        stall = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) stall = !stall;
            rand_data();
            for (int k = 0; k < NSLV; k++) begin
                SRDY[k] = stall ? 1'b0 : ($urandom_range(0, 2) != 0);
                SERR[k] = ($urandom_range(0, 7) == 0);
            end
            MsREQ = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0:       DmRMUX = '0;
                1:       DmRMUX = NSLV'($urandom());
                default: DmRMUX = NSLV'(1) << $urandom_range(0, NSLV - 1);
            endcase
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
